// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared sizing, tag types and modulo pointer helper for the rename free list
package free_list_pkg;
  localparam int N_WAY        = 3;
  localparam int XLEN         = 32;
  localparam int PR_SIZE      = 64;
  localparam int CDB_BITS     = $clog2(PR_SIZE);
  localparam int FL_DEPTH     = PR_SIZE - 1 - XLEN;
  localparam int FL_PTR_BITS  = $clog2(FL_DEPTH);
  localparam int WAY_CNT_BITS = $clog2(N_WAY + 1);

  typedef logic [FL_PTR_BITS-1:0] fl_ptr_t;
  typedef logic [CDB_BITS-1:0]    tag_t;

  // Depth is not a power of two; both operands are < FL_DEPTH so one subtract suffices.
  function automatic fl_ptr_t fl_wrap_add(input fl_ptr_t ptr, input fl_ptr_t off);
    logic [FL_PTR_BITS:0] sum;
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (FL_PTR_BITS + 1)'(FL_DEPTH))
      sum = sum - (FL_PTR_BITS + 1)'(FL_DEPTH);
    return sum[FL_PTR_BITS-1:0];
  endfunction
endpackage

// File: rtl/fl_prefix_sel.sv
// rtl/fl_prefix_sel.sv - exclusive prefix count of set bits, plus total, over a way mask
module fl_prefix_sel #(
  parameter int WIDTH    = 3,
  parameter int CNT_BITS = 2
) (
  input  logic [WIDTH-1:0]               mask,
  output logic [WIDTH-1:0][CNT_BITS-1:0] offset,
  output logic [CNT_BITS-1:0]            total
);
  always_comb begin
    offset = '0;
    total  = '0;
    for (int n = 0; n < WIDTH; n++) begin
      offset[n] = total;
      total     = total + CNT_BITS'(mask[n]);
    end
  end
endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - N-way circular physical-register free list with one-cycle mispredict recovery
module free_list
  import free_list_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_WAY-1:0]                  dis_req,
  input  logic [N_WAY-1:0]                  retire_valid,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]    retire_told,
  input  logic                              branch_haz,
  output logic [N_WAY-1:0][CDB_BITS-1:0]    pr_freelist,
  output logic [CDB_BITS-1:0]               free_count,
  output logic                              fl_empty
);
  tag_t                                entry [FL_DEPTH];
  fl_ptr_t                             head, tail, head_nxt, tail_nxt;
  logic [CDB_BITS-1:0]                 count, count_nxt;
  logic [CDB_BITS:0]                   count_sum;
  logic [N_WAY-1:0]                    push_mask;
  logic [N_WAY-1:0][WAY_CNT_BITS-1:0]  req_off, push_off;
  logic [WAY_CNT_BITS-1:0]             req_total, push_total, grant_cnt;
  logic                                dup_push;

  always_comb begin
    push_mask = '0;
    for (int n = 0; n < N_WAY; n++)
      push_mask[n] = retire_valid[n] && (retire_told[n] != '0);
  end

  fl_prefix_sel #(.WIDTH(N_WAY), .CNT_BITS(WAY_CNT_BITS)) u_req_sel (
    .mask   (dis_req),
    .offset (req_off),
    .total  (req_total)
  );

  fl_prefix_sel #(.WIDTH(N_WAY), .CNT_BITS(WAY_CNT_BITS)) u_push_sel (
    .mask   (push_mask),
    .offset (push_off),
    .total  (push_total)
  );

  // A way is granted when fewer than count requests precede it, which keeps grants in-order.
  always_comb begin
    pr_freelist = '0;
    for (int n = 0; n < N_WAY; n++)
      if (dis_req[n] && (CDB_BITS'(req_off[n]) < count))
        pr_freelist[n] = entry[fl_wrap_add(head, FL_PTR_BITS'(req_off[n]))];
  end

  always_comb begin
    grant_cnt = (CDB_BITS'(req_total) > count) ? count[WAY_CNT_BITS-1:0] : req_total;
    tail_nxt  = fl_wrap_add(tail, FL_PTR_BITS'(push_total));
    head_nxt  = branch_haz ? tail_nxt : fl_wrap_add(head, FL_PTR_BITS'(grant_cnt));
    count_sum = {1'b0, count} + (CDB_BITS + 1)'(push_total) - (CDB_BITS + 1)'(grant_cnt);
    count_nxt = branch_haz ? CDB_BITS'(FL_DEPTH) : count_sum[CDB_BITS-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++)
        entry[i] <= tag_t'(XLEN + 1 + i);
      head  <= '0;
      tail  <= '0;
      count <= CDB_BITS'(FL_DEPTH);
    end else begin
      for (int n = 0; n < N_WAY; n++)
        if (push_mask[n])
          entry[fl_wrap_add(tail, FL_PTR_BITS'(push_off[n]))] <= retire_told[n];
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
    end
  end

  assign free_count = count;
  assign fl_empty   = (count == '0);

  // Returning a tag that is already sitting in the free window is an upstream bug.
  always_comb begin
    dup_push = 1'b0;
    for (int n = 0; n < N_WAY; n++)
      for (int i = 0; i < FL_DEPTH; i++)
        if (push_mask[n] && (CDB_BITS'(i) < count) &&
            (entry[fl_wrap_add(head, FL_PTR_BITS'(i))] == retire_told[n]))
          dup_push = 1'b1;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !branch_haz |-> (count_sum <= (CDB_BITS + 1)'(FL_DEPTH)));

  a_no_dup_push: assert property (@(posedge clock) disable iff (reset) !dup_push);
endmodule
